// File: rtl/aq_spsram_1024x64_ctrl_if.sv
// Request/response and SRAM macro pin bundle for the LSU 1024x64 SRAM access controller.
// The controller uses the slave view; the requester/macro side uses the master view.
interface aq_spsram_1024x64_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  init_req;
    logic                  init_busy;

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [MASK_WIDTH-1:0] wr_bmask;
    logic                  wr_gnt;

    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  init_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_bmask, sram_q,
        output init_busy, rd_gnt, rd_vld, rd_data, wr_gnt,
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );

    modport master (
        output init_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_bmask, sram_q,
        input  init_busy, rd_gnt, rd_vld, rd_data, wr_gnt,
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );
endinterface

// File: rtl/aq_spsram_1024x64_ctrl.sv
// Access controller for the LSU 1024x64 single-port SRAM: read/write arbitration with
// round-robin on contention, and a full-array clear sweep after reset or on init_req.
module aq_spsram_1024x64_ctrl #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input logic                     forever_cpuclk,
    input logic                     cpurst,
    aq_spsram_1024x64_ctrl_if.slave bus
);
    localparam int                    MASK_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  rr_prio_q;
    logic                  rd_vld_q;
    logic                  contended;
    logic [DATA_WIDTH-1:0] wr_wen;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            init_cnt_q <= '0;
            rr_prio_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
            end
            if (contended) begin
                rr_prio_q <= ~rr_prio_q;
            end
            rd_vld_q <= bus.rd_gnt;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_cnt_q == LAST_ADDR) state_d = ST_IDLE;
            ST_IDLE: if (bus.init_req)            state_d = ST_INIT;
            default:                              state_d = ST_INIT;
        endcase
    end

    // Byte mask expanded to the macro's active-low per-bit write enables.
    always_comb begin
        wr_wen = '1;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            wr_wen[8*i +: 8] = {8{~bus.wr_bmask[i]}};
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        bus.rd_gnt    = 1'b0;
        bus.wr_gnt    = 1'b0;
        bus.sram_cen  = 1'b1;
        bus.sram_gwen = 1'b1;
        bus.sram_wen  = '1;
        bus.sram_a    = bus.rd_addr;
        bus.sram_d    = bus.wr_data;
        contended     = 1'b0;

        if (!cpurst) begin
            case (state_q)
                ST_INIT: begin
                    bus.sram_cen  = 1'b0;
                    bus.sram_gwen = 1'b0;
                    bus.sram_wen  = '0;
                    bus.sram_a    = init_cnt_q;
                    bus.sram_d    = INIT_VAL;
                end
                ST_IDLE: begin
                    if (!bus.init_req) begin
                        contended = bus.rd_req & bus.wr_req;
                        if (bus.rd_req && (!bus.wr_req || !rr_prio_q)) begin
                            bus.rd_gnt   = 1'b1;
                            bus.sram_cen = 1'b0;
                            bus.sram_a   = bus.rd_addr;
                        end else if (bus.wr_req) begin
                            // An all-zero mask is still granted but skips the macro access.
                            bus.wr_gnt    = 1'b1;
                            bus.sram_cen  = ~|bus.wr_bmask;
                            bus.sram_gwen = 1'b0;
                            bus.sram_wen  = wr_wen;
                            bus.sram_a    = bus.wr_addr;
                            bus.sram_d    = bus.wr_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.init_busy = cpurst | (state_q == ST_INIT);
    assign bus.rd_vld    = rd_vld_q & ~cpurst;
    assign bus.rd_data   = bus.sram_q;
endmodule

// File: tb/tb_aq_spsram_1024x64_ctrl.sv
// Directed bench for aq_spsram_1024x64_ctrl with a behavioural macro model and a
// read-data scoreboard drained by an independent monitor.
module tb_aq_spsram_1024x64_ctrl;
    logic clk = 1'b0;
    logic cpurst;

    aq_spsram_1024x64_ctrl_if bus ();

    aq_spsram_1024x64_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst        (cpurst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Behavioural single-port macro: write with bit mask, or read into q.
    logic [63:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.sram_cen === 1'b0) begin
            if (bus.sram_gwen === 1'b0)
                mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
            else
                bus.sram_q <= mem[bus.sram_a];
        end
    end

    // Monitor: every rd_vld consumes one expected read value.
    always @(negedge clk) begin
        if (bus.rd_vld === 1'b1) begin
            check("rd_vld_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("rd_data", bus.rd_data, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Starts at posedge+1 of sweep cycle 0, returns at posedge+1 of the cycle after the sweep.
    task automatic sweep_check(input string name);
        int errs = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (bus.init_busy !== 1'b1 || bus.sram_cen !== 1'b0 || bus.sram_gwen !== 1'b0 ||
                bus.sram_wen !== 64'h0 || bus.sram_a !== 10'(i) || bus.sram_d !== 64'h0 ||
                bus.rd_gnt !== 1'b0 || bus.wr_gnt !== 1'b0)
                errs++;
            @(posedge clk); #1;
        end
        check(name, 64'(errs), 64'd0);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [63:0] exp, output int waited);
        waited = 0;
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        @(negedge clk);
        while (bus.rd_gnt !== 1'b1 && waited < 1100) begin
            @(negedge clk);
            waited++;
        end
        check("rd_gnt", bus.rd_gnt, 64'd1);
        check("rd_excl", bus.wr_gnt, 64'd0);
        if (bus.rd_gnt === 1'b1) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [63:0] d, input logic [7:0] m,
                            input logic [63:0] exp_wen, output int waited);
        waited = 0;
        bus.wr_req   = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_bmask = m;
        @(negedge clk);
        while (bus.wr_gnt !== 1'b1 && waited < 1100) begin
            @(negedge clk);
            waited++;
        end
        check("wr_gnt", bus.wr_gnt, 64'd1);
        check("wr_cen", bus.sram_cen, 64'(m == 8'h0));
        if (m != 8'h0) begin
            check("wr_wen", bus.sram_wen, exp_wen);
            check("wr_gwen", bus.sram_gwen, 64'd0);
        end
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
    endtask

    // Expects rd_req already held; checks the grant lands in the first post-sweep cycle.
    task automatic first_grant(input string name, input logic [63:0] exp);
        @(negedge clk);
        check(name, bus.rd_gnt, 64'd1);
        check("busy_low_after_sweep", bus.init_busy, 64'd0);
        if (bus.rd_gnt === 1'b1) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
    endtask

    logic [1:0] rr_exp [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [1:0] rr_got;
    int w;

    initial begin
        cpurst       = 1'b1;
        bus.init_req = 1'b0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_req   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_bmask = '0;

        // Reset state
        @(negedge clk);
        check("rst_cen", bus.sram_cen, 64'd1);
        check("rst_busy", bus.init_busy, 64'd1);
        check("rst_gnt", {bus.rd_gnt, bus.wr_gnt}, 64'd0);
        check("rst_vld", bus.rd_vld, 64'd0);
        @(posedge clk); #1;
        cpurst = 1'b0;
        sweep_check("sweep_after_reset");

        // First grant right after the sweep; cleared data reads back as zero
        do_read(10'd5, 64'h0, w);
        check("first_rd_wait", 64'(w), 64'd0);

        // Full write then back-to-back read
        do_write(10'd10, 64'h1122334455667788, 8'hFF, 64'h0, w);
        check("wr_b2b_wait", 64'(w), 64'd0);
        do_read(10'd10, 64'h1122334455667788, w);
        check("rd_b2b_wait", 64'(w), 64'd0);

        // Partial write of byte 0
        do_write(10'd10, 64'hFFFFFFFFFFFFFFFF, 8'h01, 64'hFFFFFFFFFFFFFF00, w);
        do_read(10'd10, 64'h11223344556677FF, w);

        // Zero mask: granted, macro untouched
        do_write(10'd10, 64'h0, 8'h00, 64'h0, w);
        do_read(10'd10, 64'h11223344556677FF, w);

        // Contended requests alternate rd, wr, rd, wr
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 10'd30;
        bus.wr_req   = 1'b1;
        bus.wr_addr  = 10'd20;
        bus.wr_data  = 64'hA5A5A5A5A5A5A5A5;
        bus.wr_bmask = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rr_got = {bus.rd_gnt, bus.wr_gnt};
            check($sformatf("rr_%0d", c), 64'(rr_got), 64'(rr_exp[c]));
            if (bus.rd_gnt === 1'b1) exp_q.push_back(64'h0);
            @(posedge clk); #1;
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        do_read(10'd20, 64'hA5A5A5A5A5A5A5A5, w);

        // Read granted, then init_req (with a competing read) the next cycle
        do_read(10'd10, 64'h11223344556677FF, w);
        bus.init_req = 1'b1;
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 10'd10;
        @(negedge clk);
        check("init_req_vld", bus.rd_vld, 64'd1);
        check("init_req_gnt", {bus.rd_gnt, bus.wr_gnt}, 64'd0);
        check("init_req_cen", bus.sram_cen, 64'd1);
        @(posedge clk); #1;
        bus.init_req = 1'b0;
        sweep_check("sweep_on_init_req");
        first_grant("grant_after_init_req", 64'h0);

        // Reset in the middle of a sweep
        bus.init_req = 1'b1;
        @(posedge clk); #1;
        bus.init_req = 1'b0;
        repeat (500) begin
            @(posedge clk); #1;
        end
        check("sweep_at_500", bus.sram_a, 64'd500);
        cpurst      = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 10'd40;
        @(negedge clk);
        check("midrst_cen", bus.sram_cen, 64'd1);
        check("midrst_busy", bus.init_busy, 64'd1);
        check("midrst_gnt", {bus.rd_gnt, bus.wr_gnt}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_cen2", bus.sram_cen, 64'd1);
        @(posedge clk); #1;
        cpurst = 1'b0;
        sweep_check("sweep_after_midrst");
        first_grant("grant_after_midrst", 64'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
